// File: rtl/tdm_pkg.sv
// Shared types for the TDM burst pair sequencer: FSM states, default widths
// and the output tag that travels alongside the adder pipeline.
package tdm_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefPpLat = 2;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain,
    StGuard
  } state_e;

  typedef struct packed {
    logic valid;
    logic sop;
    logic last;
  } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that carries output tags so they line up with
// the sum leaving the external adder.
module tag_delay_line
  import tdm_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/burst_pair_sequencer.sv
// Pairs beats from two burst channels into adder operands, tags the adder
// output, and enforces guard gaps, a length cap and matched burst lengths.
module burst_pair_sequencer
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned MAX_BURST    = 256,
  parameter int unsigned PP_LAT       = DefPpLat
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] pp_din0,
  output logic [DATA_W-1:0] pp_din1,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_last,
  output logic [15:0]       burst_cnt,
  output logic              err_len_mismatch,
  output logic              err_overlength,
  input  logic              clear_err
);

  localparam int unsigned CntW      = $clog2(MAX_BURST + 1);
  localparam int unsigned GuardW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int unsigned GuardLast = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam logic [CntW-1:0]   MaxBeat    = CntW'(MAX_BURST);
  localparam logic [GuardW-1:0] GuardLastV = GuardW'(GuardLast);
  localparam state_e AfterBurst = (GUARD_CYCLES == 0) ? StIdle : StGuard;

  state_e            state_q, state_d;
  logic [CntW-1:0]   beat_q, beat_d, beat_num;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] pp0_q, pp1_q;
  logic [15:0]       burst_cnt_q;
  logic              err_len_q, err_ovl_q;
  logic              fire, inc_burst, set_len, set_ovl;
  tag_t              tag_in, tag_out;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    guard_d   = '0;
    done0_d   = done0_q;
    done1_d   = done1_q;
    tag_in    = '0;
    inc_burst = 1'b0;
    set_len   = 1'b0;
    set_ovl   = 1'b0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    // Ready is held low while in reset so every output reads 0.
    fire      = rst_n & s0_valid & s1_valid &
                ((state_q == StIdle) || (state_q == StActive));
    beat_num  = (state_q == StIdle) ? CntW'(1) : beat_q + CntW'(1);

    unique case (state_q)
      StIdle, StActive: begin
        s0_ready = fire;
        s1_ready = fire;
        if (fire) begin
          tag_in.valid = 1'b1;
          tag_in.sop   = (state_q == StIdle);
          beat_d       = beat_num;
          state_d      = StActive;
          if (s0_last && s1_last) begin
            tag_in.last = 1'b1;
            inc_burst   = 1'b1;
            state_d     = AfterBurst;
          end else if (s0_last || s1_last) begin
            tag_in.last = 1'b1;
            set_len     = 1'b1;
            inc_burst   = 1'b1;
            done0_d     = s0_last;
            done1_d     = s1_last;
            state_d     = StDrain;
          end else if (beat_num == MaxBeat) begin
            tag_in.last = 1'b1;
            set_ovl     = 1'b1;
            inc_burst   = 1'b1;
            done0_d     = 1'b0;
            done1_d     = 1'b0;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        // Discard remaining beats until each unfinished channel shows its last.
        s0_ready = rst_n & ~done0_q;
        s1_ready = rst_n & ~done1_q;
        if (s0_valid && s0_ready && s0_last) done0_d = 1'b1;
        if (s1_valid && s1_ready && s1_last) done1_d = 1'b1;
        if (done0_d && done1_d) state_d = AfterBurst;
      end
      StGuard: begin
        if (guard_q == GuardLastV) state_d = StIdle;
        else guard_d = guard_q + GuardW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      guard_q     <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      pp0_q       <= '0;
      pp1_q       <= '0;
      burst_cnt_q <= '0;
      err_len_q   <= 1'b0;
      err_ovl_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      guard_q   <= guard_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      // Zero operands outside a handshake keep the idle sum at 0.
      pp0_q     <= fire ? s0_data : '0;
      pp1_q     <= fire ? s1_data : '0;
      if (inc_burst) burst_cnt_q <= burst_cnt_q + 16'd1;
      err_len_q <= set_len | (err_len_q & ~clear_err);
      err_ovl_q <= set_ovl | (err_ovl_q & ~clear_err);
    end
  end

  tag_delay_line #(
    .Depth(1 + PP_LAT)
  ) u_tag_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign pp_din0          = pp0_q;
  assign pp_din1          = pp1_q;
  assign out_valid        = tag_out.valid;
  assign out_sop          = tag_out.sop;
  assign out_last         = tag_out.last;
  assign burst_cnt        = burst_cnt_q;
  assign err_len_mismatch = err_len_q;
  assign err_overlength   = err_ovl_q;

endmodule

// File: doc/burst_pair_sequencer.md
# burst_pair_sequencer

Sequences paired data bursts from two input channels into the 100 MHz two-operand post-processing adder. Pops one beat from each channel per cycle, drives the adder operands, and produces valid/first/last tags aligned with the adder output. Enforces TDM guard gaps between bursts, a maximum burst length, and matched burst lengths, with drain-and-discard recovery on error.

## Interface
- DATA_W, 16, operand/result width
- GUARD_CYCLES, 4, idle cycles forced between bursts (0 allowed)
- MAX_BURST, 256, maximum beats per burst (≥2)
- PP_LAT, 2, adder latency in cycles, operand register to sum output
- clk  in  1  system clock, 100 MHz; the only clock
- rst_n  in  1  asynchronous, active-low reset
- s0_data / s1_data  in  DATA_W  channel beat data
- s0_valid / s1_valid  in  1  beat present
- s0_last / s1_last  in  1  final beat of burst
- s0_ready / s1_ready  out  1  beat accepted when valid & ready
- pp_din0 / pp_din1  out  DATA_W  registered adder operands
- out_valid  out  1  adder output holds a valid sum this cycle
- out_sop / out_last  out  1  first / last beat of the output burst
- burst_cnt  out  16  completed output bursts, wraps at 2^16
- err_len_mismatch  out  1  sticky: burst lengths differed
- err_overlength  out  1  sticky: MAX_BURST reached without last
- clear_err  in  1  clears both sticky errors

## Operation
- States: IDLE, ACTIVE, DRAIN, GUARD.
- fire = s0_valid & s1_valid & (state is IDLE or ACTIVE); s0_ready = s1_ready = fire outside DRAIN. Ready depends on valid; valid never waits on ready.
- IDLE: fire moves to ACTIVE, beat tagged sop, beat counter = 1.
- ACTIVE: each fire increments beat counter.
  - Both last on the same fire: tag last, burst_cnt++, go to GUARD.
  - Exactly one last: tag last, set err_len_mismatch, burst_cnt++. The channel whose last arrived is done. Go to DRAIN.
  - Counter reaches MAX_BURST with neither last: tag last, set err_overlength, burst_cnt++, both channels not done, go to DRAIN.
  - Both last on a MAX_BURST beat: normal completion, no error.
- DRAIN:
  - Each not-done channel has ready = 1. Its beats are discarded and never reach pp_din.
  - A channel becomes done when its last is accepted.
  - When both channels are done, go to GUARD.
- GUARD: ready = 0 for GUARD_CYCLES cycles, then IDLE. If GUARD_CYCLES = 0, go to IDLE directly.
- Operands:
  - On fire, pp_din0/pp_din1 capture s0_data/s1_data.
  - On any other cycle they load 0, so the idle sum is 0.
  - The sum wraps modulo 2^DATA_W; overflow is neither flagged nor saturated.
- Errors:
  - err_* set in the cycle after the triggering fire.
  - clear_err clears both; a same-cycle set wins over clear.
- Reset mid-burst: state goes to IDLE, all outputs and the tag pipeline clear, and the partial burst is abandoned. The adder has no reset, so it may still present stale sums, but out_valid stays 0.
- Reset values: every output is 0; state is IDLE.

## Timing
- Handshake at cycle t:
  - pp_din valid in cycle t+1.
  - Sum on the adder output and out_valid/out_sop/out_last in cycle t+1+PP_LAT (t+3 by default).
- Throughput: one pair per cycle in ACTIVE; bubbles only where one channel's valid is low.
- Minimum gap from an out_last beat to the next out_sop beat is GUARD_CYCLES+1 cycles (DRAIN extends it).
- burst_cnt updates the cycle after the last handshake, not with the tag.

## Structure
- Package tdm_pkg holds:
  - state enum (IDLE, ACTIVE, DRAIN, GUARD)
  - DATA_W default and PP_LAT default
  - tag struct {valid, sop, last}
- Sub-module tag_delay_line: parameterised depth (1+PP_LAT) shift register for the tag struct, async reset to all-zero.
- The FSM, beat counter, guard counter, done flags and error registers stay in burst_pair_sequencer.

## Test plan
- Matched 4-beat bursts, s0 = 1,2,3,4 and s1 = 10,20,30,40, always valid → sums 11,22,33,44. out_valid starts 3 cycles after the first handshake; sop on 11, last on 44; burst_cnt = 1; next sop no earlier than 5 cycles after 44.
- s0 is 3 beats, s1 is 5 beats → 3 summed beats with last on the 3rd; err_len_mismatch = 1; s1's remaining 2 beats are accepted and discarded; GUARD follows.
- MAX_BURST = 8, both channels 10 beats → last forced on beat 8; err_overlength = 1; beats 9-10 drained from both; burst_cnt = 1.
- s1_valid toggles every other cycle during a 6-beat burst → out_valid shows matching bubbles, and pp_din is 0 in bubble cycles.
- rst_n asserted after beat 2 of 6 → all outputs 0 immediately. The next burst after release starts with sop and its sum is 0x0000 + 0x0001 = 1.
- clear_err asserted in the same cycle a mismatch sets the error → error remains 1. clear_err asserted alone later → error = 0.
